// File: rtl/bus_pkg.sv
// Shared bus definitions: handshake state encoding and opcode values,
// used by the server, the clients and the arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_WAIT    = 2'b01,
        S_ACK     = 2'b10,
        S_RELEASE = 2'b11
    } bus_state_t;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    // Wide enough for the full 0..15 wait-state range.
    localparam int WAIT_CNT_W = 4;

    // Index width for a word count; never zero so a single-word file still has a port.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/server_regfile.sv
// Register-file memory behind the bus server: one synchronous write port,
// one combinational read port, asynchronous active-low clear to RESET_VALUE.
module server_regfile #(
    parameter int WORDS       = 4,
    parameter int WIDTH       = 8,
    parameter int IDX_W       = 2,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [WORDS];
    logic [WIDTH-1:0] mem_d [WORDS];

    always_comb begin
        mem_d = mem_q;
        if (we && (int'(waddr) < WORDS)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= WIDTH'(RESET_VALUE);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads beyond the word count return zero; the server only reads in-range slots.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < WORDS) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/bus_server.sv
// Responder end of the arbitrated client bus: four-phase rq/ack handshake with
// programmable wait states in front of a register file. Optional err output: BUS_SERVER_ERR_EN.
module bus_server
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH           = 8,
    parameter int ADDR_WIDTH           = 4,
    parameter int ADDR_SPACE_BEGINNING = 0,
    parameter int ADDR_SPACE_END       = 3,
    parameter int WAIT_STATES          = 2,
    parameter int RESET_VALUE          = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rq,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  wr_ni,
    input  logic [DATA_WIDTH-1:0] dataW,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] dataR,
    output logic                  busy
`ifdef BUS_SERVER_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int WORDS = ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
    localparam int IDX_W = idx_width(WORDS);

    bus_state_t state_q, state_d;

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_ni_q, wr_ni_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] data_r_q, data_r_d;

    logic                  in_range;
    logic [IDX_W-1:0]      mem_idx;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Range check and index always work on the captured address, never the live bus.
    always_comb begin
        in_range = (int'(addr_q) >= ADDR_SPACE_BEGINNING) &&
                   (int'(addr_q) <= ADDR_SPACE_END);
        mem_idx  = IDX_W'(int'(addr_q) - ADDR_SPACE_BEGINNING);
    end

    server_regfile #(
        .WORDS       (WORDS),
        .WIDTH       (DATA_WIDTH),
        .IDX_W       (IDX_W),
        .RESET_VALUE (RESET_VALUE)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mem_we),
        .waddr   (mem_idx),
        .wdata   (wdata_q),
        .raddr   (mem_idx),
        .rdata   (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wr_ni_d  = wr_ni_q;
        wdata_d  = wdata_q;
        data_r_d = data_r_q;
        mem_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rq) begin
                    addr_d  = address;
                    wr_ni_d = wr_ni;
                    wdata_d = dataW;
                    cnt_d   = WAIT_CNT_W'(WAIT_STATES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A dropped request wins over a pending acknowledge.
                if (!rq) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_ACK;
                    if (wr_ni_q == BUS_WRITE) begin
                        mem_we = in_range;
                    end else if (in_range) begin
                        data_r_d = mem_rdata;
                    end else begin
`ifdef BUS_SERVER_ERR_EN
                        data_r_d = data_r_q;
`else
                        data_r_d = '0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!rq) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wr_ni_q  <= BUS_READ;
            wdata_q  <= '0;
            data_r_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wr_ni_q  <= wr_ni_d;
            wdata_q  <= wdata_d;
            data_r_q <= data_r_d;
        end
    end

    assign ack   = (state_q == S_ACK);
    assign busy  = (state_q != S_IDLE);
    assign dataR = data_r_q;

`ifdef BUS_SERVER_ERR_EN
    assign err = (state_q == S_ACK) && !in_range;
`endif

endmodule

// File: tb/tb_bus_server.sv
// Self-checking bench for bus_server: randomized transactions against a
// behavioural memory model, plus directed handshake, abort and reset scenarios.
module tb_bus_server;

    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int A_BEGIN = 0;
    localparam int A_END   = 3;
    localparam int WS      = 2;
    localparam int RST_VAL = 0;

    logic          clk;
    logic          reset_n;
    logic          rq;
    logic [AW-1:0] address;
    logic          wr_ni;
    logic [DW-1:0] dataW;
    logic          ack;
    logic [DW-1:0] dataR;
    logic          busy;
`ifdef BUS_SERVER_ERR_EN
    logic          err;
`endif

    int n_cmp;
    int n_bad;

    logic [DW-1:0] model_mem [1 << AW];
    logic [DW-1:0] model_r;

    bus_server #(
        .DATA_WIDTH           (DW),
        .ADDR_WIDTH           (AW),
        .ADDR_SPACE_BEGINNING (A_BEGIN),
        .ADDR_SPACE_END       (A_END),
        .WAIT_STATES          (WS),
        .RESET_VALUE          (RST_VAL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rq      (rq),
        .address (address),
        .wr_ni   (wr_ni),
        .dataW   (dataW),
        .ack     (ack),
        .dataR   (dataR),
        .busy    (busy)
`ifdef BUS_SERVER_ERR_EN
        ,
        .err     (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic in_rng(input int a);
        return (a >= A_BEGIN) && (a <= A_END);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < (1 << AW); i++) model_mem[i] = DW'(RST_VAL);
        model_r = '0;
    endtask

    // One full handshake; the client raises rq just after an edge, so ack is
    // expected after WS+2 further edges (capture edge, WS+1 wait cycles).
    task automatic run_txn(input logic [AW-1:0] a, input logic rd,
                           input logic [DW-1:0] d, input int hold, input string tag);
        int   edges;
        logic seen;
        @(posedge clk); #1;
        rq = 1'b1; address = a; wr_ni = rd; dataW = d;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                address = AW'($urandom);
                wr_ni   = 1'($urandom);
                dataW   = DW'($urandom);
            end
            if (ack) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || edges != WS + 2) begin
            n_bad++;
            $display("[TB] FAIL %s latency: ack after %0d edges (seen=%0b), required %0d", tag, edges, seen, WS + 2);
            if (!seen) begin
                rq = 1'b0;
                repeat (4) @(posedge clk);
                return;
            end
        end
        if (in_rng(int'(a))) begin
            if (rd) model_r = model_mem[a];
            else    model_mem[a] = d;
        end else if (rd) begin
`ifndef BUS_SERVER_ERR_EN
            model_r = '0;
`endif
        end
        n_cmp++;
        if (dataR !== model_r) begin
            n_bad++;
            $display("[TB] FAIL %s dataR@ack: got %h, required %h", tag, dataR, model_r);
        end
`ifdef BUS_SERVER_ERR_EN
        n_cmp++;
        if (err !== !in_rng(int'(a))) begin
            n_bad++;
            $display("[TB] FAIL %s err@ack: got %b, required %b", tag, err, !in_rng(int'(a)));
        end
`endif
        @(posedge clk); #1;
        n_cmp++;
        if (ack !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL %s release: ack=%b busy=%b, required ack=0 busy=1", tag, ack, busy);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ack !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL %s held rq cycle %0d: ack=%b busy=%b, required ack=0 busy=1", tag, h, ack, busy);
            end
        end
        rq = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || ack !== 1'b0 || dataR !== model_r) begin
            n_bad++;
            $display("[TB] FAIL %s idle after release: busy=%b ack=%b dataR=%h, required 0 0 %h", tag, busy, ack, dataR, model_r);
        end
    endtask

    task automatic test_reset();
        rq = 1'b0; address = '0; wr_ni = 1'b1; dataW = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ack !== 1'b0 || busy !== 1'b0 || dataR !== '0) begin
                n_bad++;
                $display("[TB] FAIL reset_idle cycle %0d: ack=%b busy=%b dataR=%h, required 0 0 00", i, ack, busy, dataR);
            end
        end
    endtask

    task automatic test_write_read();
        run_txn(4'd2, 1'b0, 8'hA5, 0, "wr_a5");
        run_txn(4'd2, 1'b1, 8'h00, 0, "rd_a5");
        n_cmp++;
        if (dataR !== 8'hA5) begin
            n_bad++;
            $display("[TB] FAIL readback_a5: got %h, required a5", dataR);
        end
        run_txn(4'd2, 1'b0, 8'h5A, 0, "wr_after_rd");
        n_cmp++;
        if (dataR !== 8'hA5) begin
            n_bad++;
            $display("[TB] FAIL dataR_after_write: got %h, required a5", dataR);
        end
    endtask

    task automatic test_held_rq();
        run_txn(4'd3, 1'b1, 8'h00, 10, "held_rq");
    endtask

    task automatic test_abort();
        @(posedge clk); #1;
        rq = 1'b1; address = 4'd1; wr_ni = 1'b0; dataW = 8'h3C;
        @(posedge clk); #1;
        rq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ack !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL abort cycle %0d: ack=%b busy=%b, required 0 0", i, ack, busy);
            end
        end
        run_txn(4'd1, 1'b1, 8'h00, 0, "rd_after_abort");
    endtask

    task automatic test_out_of_range();
        run_txn(4'd7, 1'b0, 8'hFF, 0, "oor_wr");
        for (int a = A_BEGIN; a <= A_END; a++) begin
            run_txn(AW'(a), 1'b1, 8'h00, 0, "oor_scan");
        end
        run_txn(4'd7, 1'b1, 8'h00, 0, "oor_rd");
    endtask

    task automatic test_midop_reset();
        run_txn(4'd0, 1'b0, 8'h77, 0, "pre_reset_wr");
        @(posedge clk); #1;
        rq = 1'b1; address = 4'd0; wr_ni = 1'b0; dataW = 8'h99;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (ack !== 1'b0 || busy !== 1'b0 || dataR !== '0) begin
            n_bad++;
            $display("[TB] FAIL midop_reset: ack=%b busy=%b dataR=%h, required 0 0 00", ack, busy, dataR);
        end
        model_reset();
        rq = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ack !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL post_reset cycle %0d: ack=%b busy=%b, required 0 0", i, ack, busy);
            end
        end
        run_txn(4'd0, 1'b1, 8'h00, 0, "rd_after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(A_BEGIN, A_END));
            run_txn(a, 1'($urandom), DW'($urandom), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_write_read();
        test_held_rq();
        test_abort();
        test_out_of_range();
        test_random();
        test_midop_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
